hamming_min_nbit_ncc: RTL and testbench
=======================================

# hamming_min_nbit_ncc

Sequential Hamming-distance search unit for the garbled-circuit benchmark suite. It streams one N-bit garbler vector against K evaluator candidates, M = N/CC bits per cycle over CC cycles per candidate. It reports the minimum distance and the index of the candidate that produced it. It generalises the single-pair serial Hamming block with a candidate count, a stall input, and a done flag.

## Interface
- N, 8, vector width in bits.
- CC, N, cycles per candidate. N % CC == 0 is required.
- K, 4, number of evaluator candidates; K ≥ 1.
- M, N/CC, derived chunk width; not overridable.
- DW, $clog2(N+1), distance width. It must hold the full value N.
- IW, max(1,$clog2(K)), index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- g_input  in  M  garbler chunk. LSB chunk first; re-streamed for every candidate.
- e_input  in  M  evaluator chunk of the current candidate, LSB chunk first.
- valid  in  1  chunk present this cycle; low = stall.
- o  out  DW  minimum distance found.
- o_idx  out  IW  index of the candidate that produced o.
- done  out  1  result valid; sticky until rst.

## Operation
- **Reset:** registered at posedge with rst=1.
  - o=0, o_idx=0, done=0.
  - Chunk counter c=0, candidate counter k=0, accumulator acc=0.
  - Inputs are ignored while rst=1.
- **Consumed cycle:** a cycle is consumed when valid=1, rst=0 and done=0.
  - part = popcount(g_input ^ e_input), width $clog2(M+1).
  - If c<CC-1: acc += part, c++.
  - If c==CC-1 (last chunk): d = acc + part.
    - If k==0 or d < o, then o←d and o_idx←k.
    - Ties keep the earlier (lower) index.
    - Then acc←0, c←0.
    - If k==K-1, set done←1; otherwise k++.
- **Stall:** valid=0 freezes c, k, acc, o and o_idx.
- **After done:** valid and data are ignored until the next rst.
- **Intermediate outputs:** o and o_idx are visible between candidates but are only meaningful when done=1.
- **Widths:** all arithmetic is unsigned, zero-extended to DW. acc never exceeds N, so there is no overflow.
- **State machine:** IDLE/RUN is implicit (done=0); FIN is done=1. Transitions are RUN→FIN on the last chunk of candidate K-1, and any→RUN on rst.

## Timing
- Chunk data is sampled at the posedge on which valid=1.
- o, o_idx and done update on the same posedge that consumes the final chunk of candidate K-1. They are visible one cycle after that chunk is presented.
- Minimum latency: K·CC valid cycles after rst deasserts.
- rst asserted mid-stream aborts the search. All partial state is discarded and the next consumed chunk is chunk 0 of candidate 0.
- rst and valid high in the same cycle: rst wins and the chunk is dropped.
- Special cases:
  - CC=1 (M=N): every consumed cycle completes a candidate.
  - K=1: o_idx stays 0.

## Structure
- Shared header: log2/clog2 helpers and the max() macro, in Common_H.vh alongside the existing ones.
- Sub-module `popcount_m #(.M)`: combinational M-bit population count with output width $clog2(M+1). It is reused by other benchmarks.
- Top level contains the counters, accumulator, comparator and result registers only.

## Test plan
- **Single-pair regression** (N=8, CC=8, K=1, valid=1 throughout):
  - G=A9, E=7B → o=4, done on the 8th cycle.
  - G=74, E=9D → o=5.
  - G=AA, E=AA → o=0.
- **Multi-candidate search** (N=8, CC=2, M=4, K=4): G=A9, E={7B,A8,FF,A9} → distances {4,1,4,0}, o=0, o_idx=3, done after 8 valid cycles.
- **Tie rule:** G=A9, E={A8,A8,00,FF} → o=1, o_idx=0 (first of the tied candidates).
- **Full-width boundary:** N=8, K=1, G=FF, E=00 → o=8 (4-bit DW, no wrap).
- **Stall:** repeat the multi-candidate case with valid toggled 1,0,0,1,… → identical result; done delayed exactly by the number of stall cycles. Once done=1, further valid pulses leave o and o_idx unchanged.
- **Mid-stream reset:** assert rst after 3 consumed chunks, then stream the full multi-candidate set → o=0, o_idx=3. done stays 0 until the final chunk.

Source files
------------

// File: rtl/hamming_min_nbit_ncc_pkg.sv
// Shared types and constant helpers for the serial minimum-Hamming-distance search.
// The helpers are evaluated at elaboration to size ports and counters.
package hamming_min_nbit_ncc_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_FIN = 1'b1
    } state_t;

    function automatic int hm_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int hm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hamming_min_nbit_ncc_popcount.sv
// Combinational M-bit population count; output is wide enough to hold the value M.
// Zero latency, no flow control.
module popcount_m
    import hamming_min_nbit_ncc_pkg::*;
#(
    parameter  int M = 4,
    localparam int W = hm_clog2(M + 1)
) (
    input  logic [M-1:0] bits_i,
    output logic [W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < M; i++) begin
            cnt_o = cnt_o + W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/hamming_min_nbit_ncc.sv
// Streams one N-bit garbler vector against K candidates, M bits per cycle, and keeps
// the minimum distance and its (lowest) candidate index; done is sticky until rst.
module hamming_min_nbit_ncc
    import hamming_min_nbit_ncc_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int CC = N,
    parameter  int K  = 4,
    localparam int M  = N / CC,
    localparam int DW = hm_clog2(N + 1),
    localparam int IW = hm_max(1, hm_clog2(K))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [M-1:0]  g_input,
    input  logic [M-1:0]  e_input,
    input  logic          valid,
    output logic [DW-1:0] o,
    output logic [IW-1:0] o_idx,
    output logic          done
);

    localparam int PW = hm_clog2(M + 1);
    localparam int CW = hm_max(1, hm_clog2(CC));

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [IW-1:0] k_q, k_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] o_q, o_d;
    logic [IW-1:0] o_idx_q, o_idx_d;

    logic [PW-1:0] part;
    logic [DW-1:0] sum;
    logic          consume;
    logic          last_chunk;
    logic          last_cand;

    popcount_m #(.M(M)) u_popcount (
        .bits_i (g_input ^ e_input),
        .cnt_o  (part)
    );

    assign sum        = acc_q + DW'(part);
    assign consume    = valid && (state_q == ST_RUN);
    assign last_chunk = (c_q == CW'(CC - 1));
    assign last_cand  = (k_q == IW'(K - 1));

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        o_d     = o_q;
        o_idx_d = o_idx_q;
        if (consume) begin
            if (!last_chunk) begin
                acc_d = sum;
                c_d   = c_q + CW'(1);
            end else begin
                // Strict less-than: on a tie the earlier candidate is kept.
                if ((k_q == '0) || (sum < o_q)) begin
                    o_d     = sum;
                    o_idx_d = k_q;
                end
                acc_d = '0;
                c_d   = '0;
                if (last_cand) begin
                    state_d = ST_FIN;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            o_q     <= '0;
            o_idx_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            o_idx_q <= o_idx_d;
        end
    end

    assign o     = o_q;
    assign o_idx = o_idx_q;
    assign done  = (state_q == ST_FIN);

endmodule

// File: tb/tb_hamming_min_nbit_ncc.sv
// Bench for the serial minimum-Hamming search: a 4-candidate 2-chunk instance and a
// single-candidate bit-serial instance, checked against a whole-vector popcount model.
module tb_hamming_min_nbit_ncc;

    logic       clk;
    logic       rst;

    logic [3:0] ga, ea;
    logic       va;
    logic [3:0] oa;
    logic [1:0] ia;
    logic       da;

    logic [0:0] gb, eb;
    logic       vb;
    logic [3:0] ob;
    logic [0:0] ib;
    logic       db;

    logic [7:0] cand [4];
    int checks;
    int errors;

    hamming_min_nbit_ncc #(.N(8), .CC(2), .K(4)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .g_input (ga),
        .e_input (ea),
        .valid   (va),
        .o       (oa),
        .o_idx   (ia),
        .done    (da)
    );

    hamming_min_nbit_ncc #(.N(8), .CC(8), .K(1)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .g_input (gb),
        .e_input (eb),
        .valid   (vb),
        .o       (ob),
        .o_idx   (ib),
        .done    (db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: full-vector distances, best = first index holding the minimum.
    task automatic model_min(input logic [7:0] g, input int upto, output int best_d, output int best_i);
        int d;
        best_d = $countones(g ^ cand[0]);
        best_i = 0;
        for (int j = 1; j <= upto; j++) begin
            d = $countones(g ^ cand[j]);
            if (d < best_d) begin
                best_d = d;
                best_i = j;
            end
        end
    endtask

    // stall_mode: 0 none, 1 two idle cycles before every second chunk, 2 random idles.
    task automatic stream_a(input string tag, input logic [7:0] g, input int stall_mode);
        int ns;
        int bd, bi;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                ns = (stall_mode == 0) ? 0 : (stall_mode == 1) ? ((c == 1) ? 2 : 0) : int'($urandom_range(0, 2));
                for (int s = 0; s < ns; s++) begin
                    va = 1'b0;
                    ga = 4'($urandom);
                    ea = 4'($urandom);
                    tick();
                end
                ga = g[c*4 +: 4];
                ea = cand[k][c*4 +: 4];
                va = 1'b1;
                if (k == 3 && c == 1) chk({tag, "_done_before_last"}, 32'(da), 32'd0);
                tick();
            end
            va = 1'b0;
            model_min(g, k, bd, bi);
            chk({tag, "_o"}, 32'(oa), 32'(bd));
            chk({tag, "_idx"}, 32'(ia), 32'(bi));
        end
        chk({tag, "_done"}, 32'(da), 32'd1);
    endtask

    task automatic run_b(input string tag, input logic [7:0] g, input logic [7:0] e, input int exp_o);
        do_reset();
        chk({tag, "_rst_done"}, 32'(db), 32'd0);
        for (int i = 0; i < 8; i++) begin
            gb = g[i];
            eb = e[i];
            vb = 1'b1;
            if (i == 7) chk({tag, "_done_before_last"}, 32'(db), 32'd0);
            tick();
        end
        vb = 1'b0;
        chk({tag, "_done"}, 32'(db), 32'd1);
        chk({tag, "_o"}, 32'(ob), 32'(exp_o));
        chk({tag, "_idx"}, 32'(ib), 32'd0);
    endtask

    initial begin
        int bd, bi;
        logic [7:0] g;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ga = 4'hF; ea = 4'h0; va = 1'b1;
        gb = 1'b1; eb = 1'b0; vb = 1'b1;
        tick();
        tick();
        chk("rst_a_o", 32'(oa), 32'd0);
        chk("rst_a_idx", 32'(ia), 32'd0);
        chk("rst_a_done", 32'(da), 32'd0);
        chk("rst_b_o", 32'(ob), 32'd0);
        chk("rst_b_idx", 32'(ib), 32'd0);
        chk("rst_b_done", 32'(db), 32'd0);
        rst = 1'b0;
        va = 1'b0;
        vb = 1'b0;

        // Single-pair, bit-serial instance.
        run_b("pair_a9_7b", 8'hA9, 8'h7B, 4);
        run_b("pair_74_9d", 8'h74, 8'h9D, 5);
        run_b("pair_aa_aa", 8'hAA, 8'hAA, 0);
        run_b("pair_ff_00", 8'hFF, 8'h00, 8);

        // Multi-candidate search.
        cand[0] = 8'h7B; cand[1] = 8'hA8; cand[2] = 8'hFF; cand[3] = 8'hA9;
        do_reset();
        stream_a("multi", 8'hA9, 0);
        chk("multi_final_o", 32'(oa), 32'd0);
        chk("multi_final_idx", 32'(ia), 32'd3);

        // Tie rule.
        cand[0] = 8'hA8; cand[1] = 8'hA8; cand[2] = 8'h00; cand[3] = 8'hFF;
        do_reset();
        stream_a("tie", 8'hA9, 0);
        chk("tie_final_o", 32'(oa), 32'd1);
        chk("tie_final_idx", 32'(ia), 32'd0);

        // Full-width distance on every candidate.
        for (int j = 0; j < 4; j++) cand[j] = 8'h00;
        do_reset();
        stream_a("full", 8'hFF, 0);
        chk("full_final_o", 32'(oa), 32'd8);

        // Stalls, then activity after done must not disturb the result.
        cand[0] = 8'h7B; cand[1] = 8'hA8; cand[2] = 8'hFF; cand[3] = 8'hA9;
        do_reset();
        stream_a("stall", 8'hA9, 1);
        for (int s = 0; s < 4; s++) begin
            va = 1'b1;
            ga = 4'hF;
            ea = 4'h0;
            tick();
        end
        va = 1'b0;
        chk("post_done_o", 32'(oa), 32'd0);
        chk("post_done_idx", 32'(ia), 32'd3);
        chk("post_done_done", 32'(da), 32'd1);

        // Mid-stream reset, with valid high during the reset cycle.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            ga = 4'h9;
            ea = 4'h6;
            va = 1'b1;
            tick();
        end
        ga = 4'hF; ea = 4'h0; va = 1'b1;
        do_reset();
        va = 1'b0;
        chk("midrst_o", 32'(oa), 32'd0);
        chk("midrst_done", 32'(da), 32'd0);
        stream_a("midrst", 8'hA9, 0);
        chk("midrst_final_o", 32'(oa), 32'd0);
        chk("midrst_final_idx", 32'(ia), 32'd3);

        // Randomized searches with random stalls; some candidates are duplicated to force ties.
        for (int it = 0; it < 20; it++) begin
            g = 8'($urandom);
            for (int j = 0; j < 4; j++) begin
                cand[j] = 8'($urandom);
                if (j > 0 && $urandom_range(0, 3) == 0) cand[j] = cand[$urandom_range(0, j - 1)];
            end
            do_reset();
            stream_a("rand", g, 2);
            model_min(g, 3, bd, bi);
            chk("rand_final_o", 32'(oa), 32'(bd));
            chk("rand_final_idx", 32'(ia), 32'(bi));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
